rr_requester: RTL and testbench

Requester-side front end for the round-robin arbiter `rr`. It owns 2**W independent channels. Each channel:
- accepts a job (a burst length) over a valid/ready handshake;
- drives `req` to the arbiter;
- consumes the returned one-hot `gnt` as a stream of beats;
- releases `req` after the last beat, leaving the arbiter free to rotate.

The block also checks the arbiter's grant for protocol violations.

---
 rtl/rr_requester.sv | 144 ++++++++++++++
 tb/tb_rr_requester.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_requester.sv
// rr_requester: per-channel job front end for the round-robin arbiter rr, plus a grant-protocol checker.
// Latency: handshake edge -> req next cycle; grant edge in REQ -> first beat next cycle; beat/done combinational on gnt.
// Backpressure: job_ready is low while a channel is busy; a missing grant in XFER stalls the burst without error.
//
// Ports:
//   clock      single clock, all state on posedge
//   reset      asynchronous, active-high; clears every channel and the error flag
//   job_valid  per-channel job offer
//   job_len    channel i burst length minus one at [i*LW +: LW]
//   job_ready  channel i is idle and can take a job (combinational from state)
//   req        registered request vector to rr
//   gnt        grant vector from rr, expected one-hot or zero
//   beat       channel i moves one beat this cycle (combinational)
//   done       channel i moves its final beat this cycle (combinational)
//   err        sticky grant-protocol violation flag (registered)
module rr_requester #(
    parameter int W  = 2,
    parameter int LW = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2**W-1:0]       job_valid,
    input  logic [(2**W)*LW-1:0]  job_len,
    output logic [2**W-1:0]       job_ready,
    output logic [2**W-1:0]       req,
    input  logic [2**W-1:0]       gnt,
    output logic [2**W-1:0]       beat,
    output logic [2**W-1:0]       done,
    output logic                  err
);

    localparam int N = 2**W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Per-channel FSM. Channels share nothing but the gnt input, so each
    // one is a fully independent instance of the same small machine.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [LW-1:0] r_cnt;
        logic [LW-1:0] w_cnt_nxt;
        logic          r_req;
        logic          w_ready;
        logic          w_beat;
        logic          w_done;
        logic          w_cnt_zero;

        assign w_cnt_zero = (r_cnt == '0);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_req   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                // req is a flop that tracks "not idle next cycle", so it rises
                // the cycle after the handshake and falls at the edge that
                // closes the done cycle, guaranteeing at least one low cycle.
                r_req   <= (w_state_nxt != S_IDLE);
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_ready     = 1'b0;
            w_beat      = 1'b0;
            w_done      = 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    w_ready = 1'b1;
                    if (job_valid[g]) begin
                        // Length is captured only here; later changes are ignored.
                        w_cnt_nxt   = job_len[g*LW +: LW];
                        w_state_nxt = S_REQ;
                    end
                end

                S_REQ: begin
                    // The first grant cycle only acknowledges; no data moves.
                    if (gnt[g]) begin
                        w_state_nxt = S_XFER;
                    end
                end

                S_XFER: begin
                    w_beat = gnt[g];
                    w_done = gnt[g] & w_cnt_zero;
                    if (gnt[g]) begin
                        if (w_cnt_zero) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt - LW'(1);
                        end
                    end
                    // No grant: the beat stalls, cnt and req hold.
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign job_ready[g] = w_ready;
        assign req[g]       = r_req;
        assign beat[g]      = w_beat;
        assign done[g]      = w_done;
    end

    // ------------------------------------------------------------------
    // Grant checker. g & (g-1) clears the lowest set bit, so any bit left
    // over means more than one grant is high. A grant on a channel whose
    // registered req is low is an orphan grant. Either case latches err.
    // ------------------------------------------------------------------
    logic w_multi_gnt;
    logic w_orphan_gnt;
    logic r_err;

    assign w_multi_gnt  = |(gnt & (gnt - {{(N-1){1'b0}}, 1'b1}));
    assign w_orphan_gnt = |(gnt & ~req);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_multi_gnt || w_orphan_gnt) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_rr_requester.sv
// tb_rr_requester: self-checking bench for rr_requester with a round-robin grant source.
// Latency: scoreboard compares beat counts when each channel signals done.
// Backpressure: grant stalls and forced grant patterns are injected through a mask/override on gnt.
module tb_rr_requester;

    localparam int W  = 2;
    localparam int LW = 4;
    localparam int N  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      job_valid = '0;
    logic [N*LW-1:0]   job_len = '0;
    logic [N-1:0]      job_ready;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic [N-1:0]      beat;
    logic [N-1:0]      done;
    logic              err;

    // Grant source controls
    logic              force_en = 1'b0;
    logic [N-1:0]      force_val = '0;
    logic [N-1:0]      stall_mask = '0;

    // Round-robin arbiter model: holds the owner while its req stays high,
    // otherwise grants the next requester after the last one served.
    logic [N-1:0]      arb_gnt;
    logic [N-1:0]      r_owner;
    logic [W-1:0]      r_ptr;

    // Scoreboard state
    int                n_cmp = 0;
    int                n_bad = 0;
    int                exp_q [N][$];
    int                beat_cnt [N];
    int                done_ord [$];
    int                done_total = 0;

    always #5 clock = ~clock;

    rr_requester #(.W(W), .LW(LW)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req       (req),
        .gnt       (gnt),
        .beat      (beat),
        .done      (done),
        .err       (err)
    );

    always_comb begin
        arb_gnt = '0;
        if ((r_owner & req) != '0) begin
            arb_gnt = r_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (arb_gnt == '0 && req[2'(int'(r_ptr) + k)]) begin
                    arb_gnt[2'(int'(r_ptr) + k)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_owner <= arb_gnt;
            for (int k = 0; k < N; k++) begin
                if (arb_gnt[k]) r_ptr <= 2'(k);
            end
        end
    end

    assign gnt = force_en ? force_val : (arb_gnt & ~stall_mask);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: push expected beat counts at handshake, pop and compare at done.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                beat_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (job_valid[i] && job_ready[i]) begin
                    exp_q[i].push_back(int'(job_len[i*LW +: LW]) + 1);
                end
                if (beat[i]) beat_cnt[i]++;
                if (done[i]) begin
                    check_val($sformatf("pending_ch%0d", i), exp_q[i].size(), 1);
                    if (exp_q[i].size() > 0) begin
                        check_val($sformatf("beats_ch%0d", i), beat_cnt[i], exp_q[i].pop_front());
                    end
                    beat_cnt[i] = 0;
                    done_ord.push_back(i);
                    done_total++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_dones(input int n, input string tag);
        int start;
        start = done_total;
        for (int k = 0; k < 300 && done_total < start + n; k++) tick();
        check_val(tag, done_total - start, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [N-1:0] m;
        logic [N-1:0] e;

        // Reset with offers present: they must be ignored.
        reset     = 1'b1;
        job_valid = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_req", req, 4'b0000);
        check_val("rst_beat", beat, 4'b0000);
        check_val("rst_done", done, 4'b0000);
        check_val("rst_err", err, 1'b0);
        check_val("rst_ready", job_ready, 4'b1111);
        reset     = 1'b0;
        job_valid = 4'b0000;
        tick();
        check_val("hs_in_reset", req, 4'b0000);

        // Single job, length 3 on channel 0
        job_len[0 +: LW] = 4'd3;
        job_valid = 4'b0001;
        check_val("t1_ready_pre", job_ready, 4'b1111);
        tick();
        job_valid = 4'b0000;
        check_val("t1_req", req, 4'b0001);
        check_val("t1_ready", job_ready, 4'b1110);
        check_val("t1_no_beat_in_req", beat, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            e = (k == 3) ? 4'b0001 : 4'b0000;
            check_val($sformatf("t1_beat%0d", k), beat, 4'b0001);
            check_val($sformatf("t1_done%0d", k), done, e);
        end
        tick();
        check_val("t1_req_low", req, 4'b0000);
        check_val("t1_beat_low", beat, 4'b0000);
        check_val("t1_err", err, 1'b0);

        // Four simultaneous single-beat jobs
        job_len   = '0;
        job_valid = 4'b1111;
        tick();
        job_valid = 4'b0000;
        check_val("t2_req", req, 4'b1111);
        check_val("t2_ready", job_ready, 4'b0000);
        base = done_ord.size();
        wait_dones(4, "t2_dones");
        m = '0;
        if (done_ord.size() >= base + 4) begin
            for (int j = 0; j < 4; j++) m[done_ord[base + j]] = 1'b1;
        end
        check_val("t2_each_once", m, 4'b1111);
        check_val("t2_err", err, 1'b0);

        // Max length on channel 2 while channel 1 requests behind it
        job_len[2*LW +: LW] = 4'd15;
        job_valid = 4'b0100;
        tick();
        job_len[1*LW +: LW] = 4'd2;
        job_valid = 4'b0010;
        tick();
        job_valid = 4'b0000;
        base = done_ord.size();
        wait_dones(2, "t3_dones");
        if (done_ord.size() >= base + 2) begin
            check_val("t3_first", done_ord[base], 2);
            check_val("t3_second", done_ord[base + 1], 1);
        end
        check_val("t3_err", err, 1'b0);

        // Grant stall mid-burst on channel 0
        job_len[0 +: LW] = 4'd5;
        job_valid = 4'b0001;
        tick();
        job_valid = 4'b0000;
        tick();
        tick();
        stall_mask = 4'b0001;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check_val($sformatf("t4_stall_beat%0d", k), beat[0], 1'b0);
            check_val($sformatf("t4_stall_req%0d", k), req[0], 1'b1);
        end
        stall_mask = 4'b0000;
        wait_dones(1, "t4_done");
        check_val("t4_err", err, 1'b0);

        // Multi-hot grant while both channels request
        job_len[1*LW +: LW] = 4'd3;
        job_len[2*LW +: LW] = 4'd3;
        job_valid = 4'b0110;
        tick();
        job_valid = 4'b0000;
        check_val("t5_err_pre", err, 1'b0);
        force_en  = 1'b1;
        force_val = 4'b0110;
        tick();
        force_en  = 1'b0;
        check_val("t5_multi", err, 1'b1);
        repeat (3) tick();
        check_val("t5_sticky", err, 1'b1);
        wait_dones(2, "t5_dones");
        reset = 1'b1;
        #1;
        check_val("t5_err_rst", err, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Orphan grant on an idle channel
        force_en  = 1'b1;
        force_val = 4'b1000;
        tick();
        force_en  = 1'b0;
        check_val("t5_orphan", err, 1'b1);
        repeat (2) tick();
        check_val("t5_sticky2", err, 1'b1);

        // Reset mid-burst after two of eight beats
        reset = 1'b1;
        tick();
        reset = 1'b0;
        job_len[1*LW +: LW] = 4'd7;
        job_valid = 4'b0010;
        tick();
        job_valid = 4'b0000;
        tick();
        tick();
        tick();
        check_val("t6_mid_beat", beat, 4'b0010);
        reset = 1'b1;
        #1;
        check_val("t6_req_drop", req, 4'b0000);
        check_val("t6_beat_drop", beat, 4'b0000);
        check_val("t6_done_drop", done, 4'b0000);
        tick();
        reset = 1'b0;
        check_val("t6_ready", job_ready, 4'b1111);
        job_len[1*LW +: LW] = 4'd2;
        job_valid = 4'b0010;
        tick();
        job_valid = 4'b0000;
        wait_dones(1, "t6_new_done");
        check_val("t6_err", err, 1'b0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
